// File: rtl/fc_layer_if.sv
// Pool-stream, weight-memory and result bundle for the fully-connected classifier.
// The master side is the surrounding fabric; the slave side is fc_layer.
interface fc_layer_if #(
  parameter int NUM_OUT = 10,
  parameter int WT_W    = 8,
  parameter int ACC_W   = 48
);
  logic [31:0]             pool_data;
  logic                    pool_data_vld;
  logic                    wt_rd_en;
  logic [7:0]              wt_addr;
  logic [NUM_OUT*WT_W-1:0] wt_data;
  logic [3:0]              digit;
  logic [ACC_W-1:0]        max_score;
  logic                    digit_vld;
  logic                    busy;
  logic                    err_overrun;

  modport master (
    output pool_data, pool_data_vld, wt_data,
    input  wt_rd_en, wt_addr, digit, max_score, digit_vld, busy, err_overrun
  );

  modport slave (
    input  pool_data, pool_data_vld, wt_data,
    output wt_rd_en, wt_addr, digit, max_score, digit_vld, busy, err_overrun
  );
endinterface

// File: rtl/fc_layer.sv
// Fully-connected classifier: NUM_OUT parallel MAC lanes over one pooled frame,
// bias add, then a one-lane-per-cycle argmax that reports the recognised digit.
module fc_layer #(
  parameter int NUM_IN  = 144,
  parameter int NUM_OUT = 10,
  parameter int WT_W    = 8,
  parameter int ACC_W   = 48
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       cal_start,
  fc_layer_if.slave  bus
);
  localparam int PROD_W = 33 + WT_W;

  typedef enum logic [2:0] {
    ST_ACCUM    = 3'd0,
    ST_BIAS_RD  = 3'd1,
    ST_BIAS_ADD = 3'd2,
    ST_ARGMAX   = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [7:0]              in_cnt_r;
  logic [31:0]             data_r;
  logic                    mac_pend_r;
  logic [3:0]              lane_idx_r;
  logic signed [ACC_W-1:0] acc_r      [NUM_OUT];
  logic signed [ACC_W-1:0] add_s      [NUM_OUT];
  logic signed [WT_W-1:0]  wt_lane_s  [NUM_OUT];
  logic signed [PROD_W-1:0] prod_s    [NUM_OUT];
  logic signed [ACC_W-1:0] best_val_r, cand_val_s, sel_val_s;
  logic [3:0]              best_idx_r, cand_idx_s;
  logic                    accept_s, drop_s, last_lane_s;
  logic                    wt_rd_en_s;
  logic [7:0]              wt_addr_s;
  logic [3:0]              digit_r;
  logic [ACC_W-1:0]        max_score_r;
  logic                    digit_vld_r, busy_r, err_overrun_r;

  assign bus.wt_rd_en    = wt_rd_en_s;
  assign bus.wt_addr     = wt_addr_s;
  assign bus.digit       = digit_r;
  assign bus.max_score   = max_score_r;
  assign bus.digit_vld   = digit_vld_r;
  assign bus.busy        = busy_r;
  assign bus.err_overrun = err_overrun_r;

  // State register
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, weight-memory request and sample accept/drop decode
  always_comb begin
    state_nxt_s = state_r;
    wt_rd_en_s  = 1'b0;
    wt_addr_s   = 8'd0;
    accept_s    = 1'b0;
    drop_s      = 1'b0;
    if (cal_start) begin
      state_nxt_s = ST_ACCUM;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if (bus.pool_data_vld) begin
            accept_s   = 1'b1;
            wt_rd_en_s = 1'b1;
            wt_addr_s  = in_cnt_r;
            if (in_cnt_r == 8'(NUM_IN - 1)) begin
              state_nxt_s = ST_BIAS_RD;
            end else begin
              state_nxt_s = ST_ACCUM;
            end
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end
        ST_BIAS_RD: begin
          wt_rd_en_s  = 1'b1;
          wt_addr_s   = 8'(NUM_IN);
          drop_s      = bus.pool_data_vld;
          state_nxt_s = ST_BIAS_ADD;
        end
        ST_BIAS_ADD: begin
          drop_s      = bus.pool_data_vld;
          state_nxt_s = ST_ARGMAX;
        end
        ST_ARGMAX: begin
          drop_s = bus.pool_data_vld;
          if (last_lane_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ARGMAX;
          end
        end
        ST_DONE: begin
          drop_s      = bus.pool_data_vld;
          state_nxt_s = ST_ACCUM;
        end
        default: begin
          state_nxt_s = ST_ACCUM;
        end
      endcase
    end
  end

  // Per-lane addend: product of the registered sample, or the sign-extended bias
  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      wt_lane_s[k] = bus.wt_data[k*WT_W +: WT_W];
      prod_s[k]    = $signed({{WT_W{1'b0}}, 1'b0, data_r}) *
                     $signed({{33{wt_lane_s[k][WT_W-1]}}, wt_lane_s[k]});
      if (mac_pend_r) begin
        add_s[k] = {{(ACC_W-PROD_W){prod_s[k][PROD_W-1]}}, prod_s[k]};
      end else if (state_r == ST_BIAS_ADD) begin
        add_s[k] = {{(ACC_W-WT_W){wt_lane_s[k][WT_W-1]}}, wt_lane_s[k]};
      end else begin
        add_s[k] = {ACC_W{1'b0}};
      end
    end
  end

  // Argmax step: lane 0 seeds, later lanes win only when strictly greater
  always_comb begin
    sel_val_s   = acc_r[lane_idx_r];
    last_lane_s = (state_r == ST_ARGMAX) && (lane_idx_r == 4'(NUM_OUT - 1));
    if (lane_idx_r == 4'd0) begin
      cand_val_s = sel_val_s;
      cand_idx_s = 4'd0;
    end else if (sel_val_s > best_val_r) begin
      cand_val_s = sel_val_s;
      cand_idx_s = lane_idx_r;
    end else begin
      cand_val_s = best_val_r;
      cand_idx_s = best_idx_r;
    end
  end

  // Sample capture, input counter and argmax scan registers
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      in_cnt_r   <= 8'd0;
      data_r     <= 32'd0;
      mac_pend_r <= 1'b0;
      lane_idx_r <= 4'd0;
      best_val_r <= {ACC_W{1'b0}};
      best_idx_r <= 4'd0;
    end else if (cal_start) begin
      in_cnt_r   <= 8'd0;
      mac_pend_r <= 1'b0;
      lane_idx_r <= 4'd0;
    end else begin
      mac_pend_r <= accept_s;
      if (accept_s) begin
        data_r   <= bus.pool_data;
        in_cnt_r <= (in_cnt_r == 8'(NUM_IN - 1)) ? 8'd0 : in_cnt_r + 8'd1;
      end
      if (state_r == ST_ARGMAX) begin
        lane_idx_r <= last_lane_s ? 4'd0 : lane_idx_r + 4'd1;
        best_val_r <= cand_val_s;
        best_idx_r <= cand_idx_s;
      end else begin
        lane_idx_r <= 4'd0;
      end
    end
  end

  // Lane accumulators; cleared on frame restart and after each reported result
  always_ff @(posedge sclk or negedge s_rst_n) begin
    for (int k = 0; k < NUM_OUT; k++) begin
      if (!s_rst_n) begin
        acc_r[k] <= {ACC_W{1'b0}};
      end else if (cal_start || (state_r == ST_DONE)) begin
        acc_r[k] <= {ACC_W{1'b0}};
      end else begin
        acc_r[k] <= acc_r[k] + add_s[k];
      end
    end
  end

  // Registered outputs; digit/max_score survive a frame restart
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      digit_r       <= 4'd0;
      max_score_r   <= {ACC_W{1'b0}};
      digit_vld_r   <= 1'b0;
      busy_r        <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ST_BIAS_RD) || (state_nxt_s == ST_BIAS_ADD) ||
                (state_nxt_s == ST_ARGMAX);
      if (cal_start) begin
        digit_vld_r   <= 1'b0;
        err_overrun_r <= 1'b0;
      end else begin
        digit_vld_r   <= last_lane_s;
        err_overrun_r <= drop_s;
        if (last_lane_s) begin
          digit_r     <= cand_idx_s;
          max_score_r <= cand_val_s;
        end
      end
    end
  end
endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer: table of whole-frame vectors with hand-computed
// results, plus sequences for overrun, frame restart and mid-frame reset.
module tb_fc_layer;
  localparam int NUM_IN  = 144;
  localparam int NUM_OUT = 10;
  localparam int WT_W    = 8;
  localparam int ACC_W   = 48;
  localparam int K_LANE = 0, K_TIE = 1, K_NEG = 2, K_BIG = 3, K_SEED = 4, K_RAMP = 5;

  typedef struct {
    int                 kind;
    int                 exp_digit;
    logic signed [63:0] exp_score;
    string              name;
  } vec_t;

  logic sclk      = 1'b0;
  logic s_rst_n   = 1'b0;
  logic cal_start = 1'b0;
  int   cyc       = 0;
  int   n_vec     = 0;
  int   n_bad     = 0;
  int   cur_kind  = 0;
  int   last_cyc  = 0;
  vec_t vecs [6];

  fc_layer_if #(.NUM_OUT(NUM_OUT), .WT_W(WT_W), .ACC_W(ACC_W)) bus();

  fc_layer #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .WT_W(WT_W), .ACC_W(ACC_W)) dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .cal_start (cal_start),
    .bus       (bus.slave)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  function automatic logic [WT_W-1:0] wgt(int kind, int row, int lane);
    int w;
    w = 0;
    if (row < NUM_IN) begin
      case (kind)
        K_LANE:  w = lane;
        K_TIE:   w = (lane == 3 || lane == 7) ? 5 : 1;
        K_NEG:   w = -1;
        K_BIG:   w = (lane == 2) ? 127 : -128;
        K_SEED:  w = -2;
        K_RAMP:  w = (lane == 4) ? ((row % 2 == 1) ? 1 : -1) : ((lane == 8 && row == 143) ? 1 : 0);
        default: w = 0;
      endcase
    end else begin
      case (kind)
        K_NEG:   w = lane;
        K_BIG:   w = (lane == 2) ? -1 : 0;
        K_SEED:  w = (lane == 0) ? 0 : -1;
        default: w = 0;
      endcase
    end
    return WT_W'(w);
  endfunction

  function automatic logic [31:0] sample(int kind, int i);
    case (kind)
      K_LANE:  return 32'd1;
      K_TIE:   return 32'd2;
      K_NEG:   return 32'd1000;
      K_BIG:   return 32'hFFFF_FFFF;
      K_SEED:  return 32'd3;
      K_RAMP:  return 32'(i);
      default: return 32'd0;
    endcase
  endfunction

  // Weight memory model with one-cycle read latency
  always @(posedge sclk) begin
    if (bus.wt_rd_en) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        bus.wt_data[k*WT_W +: WT_W] <= wgt(cur_kind, int'(bus.wt_addr), k);
      end
    end
  end

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    @(posedge sclk);
    #1;
    bus.pool_data_vld = v;
    bus.pool_data     = d;
  endtask

  task automatic send_samples(input int kind, input int count);
    cur_kind = kind;
    for (int i = 0; i < count; i++) drive(1'b1, sample(kind, i));
    last_cyc = cyc;
  endtask

  task automatic wait_result(input string nm, input int exp_d, input logic signed [63:0] exp_s,
                             input bit chk_busy);
    int busy_cnt;
    int lat;
    bit seen;
    busy_cnt = 0;
    lat      = 0;
    seen     = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge sclk);
      if (bus.busy) busy_cnt++;
      if (bus.digit_vld) begin
        seen = 1'b1;
        lat  = cyc - last_cyc;
      end
    end
    chk({nm, "_seen"}, 64'(seen), 64'sd1);
    if (seen) begin
      chk({nm, "_digit"}, 64'(bus.digit), 64'(exp_d));
      chk({nm, "_score"}, $signed(bus.max_score), exp_s);
      chk({nm, "_latency"}, 64'(lat), 64'sd13);
      if (chk_busy) chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'sd12);
    end
  endtask

  task automatic run_frame(input int idx);
    send_samples(vecs[idx].kind, NUM_IN);
    drive(1'b0, 32'd0);
    wait_result(vecs[idx].name, vecs[idx].exp_digit, vecs[idx].exp_score, 1'b1);
    @(negedge sclk);
    chk({vecs[idx].name, "_pulse"}, 64'(bus.digit_vld), 64'sd0);
  endtask

  task automatic count_dvld(input string nm, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge sclk);
      if (bus.digit_vld) n++;
    end
    chk(nm, 64'(n), 64'sd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_digit"}, 64'(bus.digit), 64'sd0);
    chk({nm, "_score"}, $signed(bus.max_score), 64'sd0);
    chk({nm, "_dvld"}, 64'(bus.digit_vld), 64'sd0);
    chk({nm, "_busy"}, 64'(bus.busy), 64'sd0);
    chk({nm, "_err"}, 64'(bus.err_overrun), 64'sd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pool_data_vld = 1'b0;
    bus.pool_data     = 32'd0;
    bus.wt_data       = '0;
    vecs[0] = '{K_LANE, 9, 64'sd1296, "lane_w"};
    vecs[1] = '{K_TIE, 3, 64'sd1440, "tie"};
    vecs[2] = '{K_NEG, 9, -64'sd143991, "neg"};
    vecs[3] = '{K_BIG, 2, 64'sd78546361890959, "big"};
    vecs[4] = '{K_SEED, 0, -64'sd864, "seed"};
    vecs[5] = '{K_RAMP, 8, 64'sd143, "ramp"};

    repeat (3) @(negedge sclk);
    chk_all_zero("reset");
    chk("reset_rd_en", 64'(bus.wt_rd_en), 64'sd0);
    @(posedge sclk);
    #1 s_rst_n = 1'b1;

    for (int v = 0; v < 6; v++) run_frame(v);

    // Strobes while busy are dropped and flagged
    send_samples(K_LANE, NUM_IN);
    drive(1'b1, 32'hDEAD_BEEF);
    @(negedge sclk);
    chk("ovr_bias_addr", 64'(bus.wt_addr), 64'sd144);
    drive(1'b0, 32'd0);
    @(negedge sclk);
    chk("ovr_err1", 64'(bus.err_overrun), 64'sd1);
    drive(1'b0, 32'd0);
    drive(1'b0, 32'd0);
    drive(1'b1, 32'h0000_1234);
    @(negedge sclk);
    chk("ovr_rd_en", 64'(bus.wt_rd_en), 64'sd0);
    drive(1'b0, 32'd0);
    @(negedge sclk);
    chk("ovr_err2", 64'(bus.err_overrun), 64'sd1);
    @(negedge sclk);
    chk("ovr_err_clr", 64'(bus.err_overrun), 64'sd0);
    wait_result("ovr", 9, 64'sd1296, 1'b0);
    @(negedge sclk);
    run_frame(1);

    // Restart after 70 samples; the strobe in the restart cycle is discarded
    send_samples(K_BIG, 70);
    @(posedge sclk);
    #1;
    cal_start         = 1'b1;
    bus.pool_data_vld = 1'b1;
    bus.pool_data     = 32'hFFFF_FFFF;
    @(posedge sclk);
    #1;
    cal_start         = 1'b0;
    bus.pool_data_vld = 1'b0;
    @(negedge sclk);
    chk("cal_err", 64'(bus.err_overrun), 64'sd0);
    chk("cal_digit_held", 64'(bus.digit), 64'sd3);
    chk("cal_score_held", $signed(bus.max_score), 64'sd1440);
    run_frame(2);

    // Restart during the argmax scan abandons the pending result
    send_samples(K_SEED, NUM_IN);
    repeat (5) drive(1'b0, 32'd0);
    @(posedge sclk);
    #1 cal_start = 1'b1;
    @(posedge sclk);
    #1 cal_start = 1'b0;
    count_dvld("cal_argmax_no_dvld", 20);
    chk("cal_argmax_digit", 64'(bus.digit), 64'sd9);
    chk("cal_argmax_score", $signed(bus.max_score), -64'sd143991);

    // Reset during the argmax scan, then recovery and back-to-back frames
    send_samples(K_TIE, NUM_IN);
    repeat (5) drive(1'b0, 32'd0);
    @(posedge sclk);
    #1 s_rst_n = 1'b0;
    @(negedge sclk);
    chk_all_zero("midrst");
    @(posedge sclk);
    #1 s_rst_n = 1'b1;
    count_dvld("midrst_no_dvld", 20);
    run_frame(0);
    run_frame(5);
    run_frame(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
